// File: rtl/pipelined_cascade_adder.sv
// Pipelined multi-operand unsigned adder built as a registered binary tree.
// Each tree level is one pipeline stage with its own valid bit and skid-free stall.
module pipelined_cascade_adder #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_OPERANDS = 4
) (
    input  logic                               clock_in,
    input  logic                               reset_in,
    input  logic [NUM_OPERANDS*DATA_WIDTH-1:0] cadd_operands_in,
    input  logic                               cadd_valid_in,
    output logic                               cadd_ready_out,
    output logic [DATA_WIDTH-1:0]              cadd_sum_out,
    output logic                               cadd_overflow_out,
    output logic                               cadd_valid_out,
    input  logic                               cadd_ready_in
);

    localparam int LEVELS = $clog2(NUM_OPERANDS);
    localparam int LANES  = 1 << LEVELS;
    localparam int SLOTS  = LANES / 2;
    // Wide enough for the full tree sum, so no level ever truncates.
    localparam int SW     = DATA_WIDTH + LEVELS;

    logic [SW-1:0]     ops    [LANES];
    logic [SW-1:0]     data_q [LEVELS][SLOTS];
    logic [SW-1:0]     data_d [LEVELS][SLOTS];
    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] valid_d;
    logic [LEVELS-1:0] load;
    logic [SW-1:0]     final_sum;

    for (genvar k = 0; k < LANES; k++) begin : g_pad
        if (k < NUM_OPERANDS) begin : g_op
            assign ops[k] = SW'(cadd_operands_in[k*DATA_WIDTH +: DATA_WIDTH]);
        end else begin : g_zero
            assign ops[k] = '0;
        end
    end

    // A stage may load if it or any stage downstream of it has room.
    always_comb begin
        logic room;
        room = cadd_ready_in;
        load = '0;
        for (int s = LEVELS - 1; s >= 0; s--) begin
            room    = room | ~valid_q[s];
            load[s] = room;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load[0]) begin
            valid_d[0] = cadd_valid_in;
            if (cadd_valid_in) begin
                for (int i = 0; i < SLOTS; i++) begin
                    data_d[0][i] = ops[2*i] + ops[2*i+1];
                end
            end
        end
        for (int s = 1; s < LEVELS; s++) begin
            if (load[s]) begin
                valid_d[s] = valid_q[s-1];
                if (valid_q[s-1]) begin
                    for (int i = 0; i < SLOTS / 2; i++) begin
                        data_d[s][i] = data_q[s-1][2*i] + data_q[s-1][2*i+1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            valid_q <= '0;
            for (int s = 0; s < LEVELS; s++) begin
                for (int i = 0; i < SLOTS; i++) begin
                    data_q[s][i] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign final_sum         = data_q[LEVELS-1][0];
    assign cadd_sum_out      = final_sum[DATA_WIDTH-1:0];
    assign cadd_overflow_out = |final_sum[SW-1:DATA_WIDTH];
    assign cadd_valid_out    = valid_q[LEVELS-1];
    // Reset empties the pipeline, so report ready while it is held.
    assign cadd_ready_out    = reset_in | load[0];

endmodule
